// File: rtl/dma_arbiter_if.sv
// dma_arbiter_if: DMA bus-mastership handshake bundle.
//   slave  modport: arbiter side (takes requests/strobe/cpu_busy, drives grant/hold/status)
//   master modport: requester/CPU side (the opposite directions)
// Signals: dma_req[NREQ], dma_gnt[NREQ], dma_stb, cpu_busy, cpu_hold, bus_master,
//          tmo_err, tmo_src[3]
interface dma_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0] dma_req;
  logic [NREQ-1:0] dma_gnt;
  logic            dma_stb;
  logic            cpu_busy;
  logic            cpu_hold;
  logic            bus_master;
  logic            tmo_err;
  logic [2:0]      tmo_src;

  modport slave (
    input  dma_req, dma_stb, cpu_busy,
    output dma_gnt, cpu_hold, bus_master, tmo_err, tmo_src
  );

  modport master (
    output dma_req, dma_stb, cpu_busy,
    input  dma_gnt, cpu_hold, bus_master, tmo_err, tmo_src
  );
endinterface

// File: rtl/dma_arbiter.sv
// dma_arbiter: shares the single DMA port between NREQ requesters (index 0 = console).
// Stalls the CPU at a bus-cycle boundary, grants one requester at a time, leaves the
// CPU at least CPU_GAP cycles between grants, and revokes a grant whose master stops
// strobing for TMO cycles (revoked master stays masked until it drops its request).
// Ports:
//   clk_p     system clock
//   sys_init  synchronous active-high reset
//   bus       dma_arbiter_if.slave: dma_req/dma_stb/cpu_busy in;
//             dma_gnt/cpu_hold/bus_master/tmo_err/tmo_src out (all registered)
// Configuration: define DMA_RR_EN for round-robin arbitration; default is fixed
// priority with index 0 highest.
module dma_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TMO     = 1024,
  parameter int unsigned CPU_GAP = 2
) (
  input  logic         clk_p,
  input  logic         sys_init,
  dma_arbiter_if.slave bus
);

  localparam int unsigned IW = 3;
  localparam int unsigned SW = IW + 1;
  localparam int unsigned CW = $clog2(TMO + 1);
  localparam int unsigned GW = (CPU_GAP > 1) ? $clog2(CPU_GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_GRANT,
    S_RELEASE
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] mask_q, mask_d;
  logic [CW-1:0]   wdog_q, wdog_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            hold_q, hold_d;
  logic            bm_q, bm_d;
  logic            err_q, err_d;
  logic [IW-1:0]   src_q, src_d;

  logic [NREQ-1:0] cand_c;
  logic [NREQ-1:0] own_bit_c;
  logic [IW-1:0]   win_c;
  logic            any_c;
  logic            own_req_c;

  assign cand_c    = bus.dma_req & ~mask_q;
  assign any_c     = |cand_c;
  assign own_bit_c = NREQ'(1) << owner_q;
  assign own_req_c = |(bus.dma_req & own_bit_c);

`ifdef DMA_RR_EN
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] rot_c;
  logic [IW-1:0]   off_c;
  logic [SW-1:0]   sum_c;

  // Rotate candidates so bit 0 is the pointer position, then find the first hit.
  assign rot_c = NREQ'({cand_c, cand_c} >> ptr_q);

  always_comb begin
    off_c = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (rot_c[i]) off_c = IW'(i);
    end
  end

  assign sum_c = {1'b0, ptr_q} + {1'b0, off_c};
  assign win_c = (sum_c >= SW'(NREQ)) ? IW'(sum_c - SW'(NREQ)) : IW'(sum_c);

  // Pointer moves past the owner on each entry to GRANT.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_HOLD && !bus.cpu_busy) begin
      ptr_d = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
    end
  end

  always_ff @(posedge clk_p) begin
    if (sys_init) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`else
  // Fixed priority: downward scan so the lowest index is assigned last.
  always_comb begin
    win_c = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (cand_c[i]) win_c = IW'(i);
    end
  end
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    mask_d  = mask_q & bus.dma_req;
    wdog_d  = wdog_q;
    gap_d   = gap_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    bm_d    = bm_q;
    err_d   = 1'b0;
    src_d   = src_q;

    unique case (state_q)
      S_IDLE: begin
        if (any_c) begin
          owner_d = win_c;
          hold_d  = 1'b1;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (!bus.cpu_busy) begin
          gnt_d   = own_bit_c;
          bm_d    = 1'b1;
          wdog_d  = '0;
          state_d = S_GRANT;
        end
      end

      S_GRANT: begin
        wdog_d = bus.dma_stb ? '0 : wdog_q + CW'(1);
        // Request drop wins over a coincident timeout.
        if (!own_req_c) begin
          gnt_d   = '0;
          state_d = S_RELEASE;
        end else if (!bus.dma_stb && wdog_q == CW'(TMO - 1)) begin
          gnt_d   = '0;
          err_d   = 1'b1;
          src_d   = owner_q;
          mask_d  = (mask_q & bus.dma_req) | own_bit_c;
          state_d = S_RELEASE;
        end
      end

      S_RELEASE: begin
        // First cycle hands the bus back to the CPU; then the gap runs down.
        if (hold_q) begin
          hold_d = 1'b0;
          bm_d   = 1'b0;
          gap_d  = GW'(CPU_GAP - 1);
        end else if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_p) begin
    if (sys_init) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      mask_q  <= '0;
      wdog_q  <= '0;
      gap_q   <= '0;
      gnt_q   <= '0;
      hold_q  <= 1'b0;
      bm_q    <= 1'b0;
      err_q   <= 1'b0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      mask_q  <= mask_d;
      wdog_q  <= wdog_d;
      gap_q   <= gap_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
      bm_q    <= bm_d;
      err_q   <= err_d;
      src_q   <= src_d;
    end
  end

  assign bus.dma_gnt    = gnt_q;
  assign bus.cpu_hold   = hold_q;
  assign bus.bus_master = bm_q;
  assign bus.tmo_err    = err_q;
  assign bus.tmo_src    = src_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// tb_dma_arbiter: directed and randomized checks of dma_arbiter against a
// timestamp-based reference model of the arbitration rules.
module tb_dma_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned TMO     = 16;
  localparam int unsigned CPU_GAP = 2;

  logic clk_p = 1'b0;
  logic sys_init;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  dma_arbiter_if #(.NREQ(NREQ)) bus ();

  dma_arbiter #(
    .NREQ   (NREQ),
    .TMO    (TMO),
    .CPU_GAP(CPU_GAP)
  ) dut (
    .clk_p   (clk_p),
    .sys_init(sys_init),
    .bus     (bus)
  );

  always #5 clk_p = ~clk_p;

  // Reference model: owner (-1 = bus free), edge of last release, idle-strobe run.
  logic [NREQ-1:0] m_mask;
  int              m_owner;
  int              m_rel;
  int              m_idle;
  int              m_ptr;
  bit              m_granted;
  logic [NREQ-1:0] e_gnt;
  logic            e_hold;
  logic            e_bm;
  logic            e_err;
  logic [2:0]      e_src;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] cand, input int start);
    for (int k = 0; k < int'(NREQ); k++) begin
      int j;
      j = (start + k) % int'(NREQ);
      if (cand[j]) return j;
    end
    return -1;
  endfunction

  function automatic int gnt_idx(input logic [NREQ-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < int'(NREQ); i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_mask = '0; m_owner = -1; m_rel = -1000; m_idle = 0; m_ptr = 0; m_granted = 0;
    e_gnt = '0; e_hold = 1'b0; e_bm = 1'b0; e_err = 1'b0; e_src = '0;
  endtask

  task automatic model_step();
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] set_m;
    int w;
    int start;
    req   = bus.dma_req;
    set_m = '0;
    e_err = 1'b0;
    cyc++;
    if (sys_init) begin
      model_reset();
      return;
    end
    if (m_granted) begin
      m_idle = bus.dma_stb ? 0 : m_idle + 1;
      if (!req[m_owner] || m_idle >= int'(TMO)) begin
        if (req[m_owner]) begin
          e_err = 1'b1;
          e_src = 3'(m_owner);
          set_m[m_owner] = 1'b1;
        end
        e_gnt = '0; m_granted = 0; m_owner = -1; m_rel = cyc;
      end
    end else if (m_owner >= 0) begin
      if (!bus.cpu_busy) begin
        m_granted = 1; m_idle = 0; e_bm = 1'b1;
        e_gnt = NREQ'(1) << m_owner;
        m_ptr = (m_owner + 1) % int'(NREQ);
      end
    end else if (cyc == m_rel + 1) begin
      e_hold = 1'b0; e_bm = 1'b0;
    end else if (cyc >= m_rel + int'(CPU_GAP) + 2) begin
`ifdef DMA_RR_EN
      start = m_ptr;
`else
      start = 0;
`endif
      w = pick(req & ~m_mask, start);
      if (w >= 0) begin
        m_owner = w; e_hold = 1'b1;
      end
    end
    m_mask = (m_mask & req) | set_m;
  endtask

  task automatic tick();
    @(posedge clk_p);
    model_step();
    #1;
    check("gnt", 32'(bus.dma_gnt), 32'(e_gnt));
    check("cpu_hold", 32'(bus.cpu_hold), 32'(e_hold));
    check("bus_master", 32'(bus.bus_master), 32'(e_bm));
    check("tmo_err", 32'(bus.tmo_err), 32'(e_err));
    check("tmo_src", 32'(bus.tmo_src), 32'(e_src));
    check("gnt_onehot", 32'($countones(bus.dma_gnt) <= 1), 1);
    check("gnt_needs_hold", 32'(bus.dma_gnt == '0 || bus.cpu_hold), 1);
  endtask

  task automatic wait_grant(input int limit, output int waited);
    waited = 0;
    while (bus.dma_gnt == '0 && waited < limit) begin
      tick();
      waited++;
    end
    check("grant_timeout", 32'(bus.dma_gnt != '0), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: observed no finish, expected finish within budget");
    $fatal(1, "simulation time budget exceeded");
  end

  initial begin
    int              waited;
    int              cnt;
    int              idx;
    logic [NREQ-1:0] r;
    bit              stb_mode;
    int              exp_order [4];

    sys_init = 1'b1; bus.dma_req = '0; bus.dma_stb = 1'b0; bus.cpu_busy = 1'b0;
    model_reset();
    tick(); tick();
    sys_init = 1'b0;
    check("rst_gnt", 32'(bus.dma_gnt), 0);
    check("rst_hold", 32'(bus.cpu_hold), 0);
    check("rst_bm", 32'(bus.bus_master), 0);
    check("rst_err", 32'(bus.tmo_err), 0);
    check("rst_src", 32'(bus.tmo_src), 0);

    // Single request, minimum latency and release timing
    bus.dma_req = 4'b0001;
    tick();
    check("single_hold", 32'(bus.cpu_hold), 1);
    check("single_gnt_early", 32'(bus.dma_gnt), 0);
    tick();
    check("single_gnt", 32'(bus.dma_gnt), 32'h1);
    check("single_bm", 32'(bus.bus_master), 1);
    bus.dma_stb = 1'b1; tick(); tick(); bus.dma_stb = 1'b0;
    bus.dma_req = '0;
    tick();
    check("drop_gnt", 32'(bus.dma_gnt), 0);
    check("drop_hold_late", 32'(bus.cpu_hold), 1);
    tick();
    check("drop_hold", 32'(bus.cpu_hold), 0);
    check("drop_bm", 32'(bus.bus_master), 0);
    repeat (4) tick();

    // CPU busy defers the grant
    bus.cpu_busy = 1'b1; bus.dma_req = 4'b0100;
    tick();
    check("busy_hold", 32'(bus.cpu_hold), 1);
    repeat (4) begin
      tick();
      check("busy_no_gnt", 32'(bus.dma_gnt), 0);
    end
    bus.cpu_busy = 1'b0;
    tick();
    check("busy_gnt", 32'(bus.dma_gnt), 32'h4);
    bus.dma_req = '0;
    repeat (6) tick();

    // Contention from a fresh pointer
    sys_init = 1'b1; tick(); sys_init = 1'b0;
`ifdef DMA_RR_EN
    exp_order = '{0, 1, 3, 0};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    bus.dma_req = 4'b1011;
    for (int g = 0; g < 4; g++) begin
      wait_grant(40, waited);
      if (g > 0) check("gap_cycles", 32'(waited), 32'(CPU_GAP + 3));
      idx = gnt_idx(bus.dma_gnt);
      check("order", 32'(idx), 32'(exp_order[g]));
      bus.dma_stb = 1'b1; tick(); bus.dma_stb = 1'b0;
      r = 4'b1011;
      if (idx >= 0) r[idx] = 1'b0;
      bus.dma_req = r;
      tick();
      bus.dma_req = 4'b1011;
    end
    bus.dma_req = '0;
    repeat (6) tick();

    // Watchdog revocation and masking
    bus.dma_req = 4'b0010; bus.dma_stb = 1'b0;
    wait_grant(40, waited);
    cnt = 0;
    while (bus.dma_gnt != '0 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("wdog_cycles", 32'(cnt), 32'(TMO));
    check("wdog_err", 32'(bus.tmo_err), 1);
    check("wdog_src", 32'(bus.tmo_src), 1);
    tick();
    check("wdog_err_pulse", 32'(bus.tmo_err), 0);
    repeat (20) begin
      tick();
      check("masked_no_gnt", 32'(bus.dma_gnt), 0);
    end
    bus.dma_req = '0; tick(); bus.dma_req = 4'b0010;
    wait_grant(40, waited);
    check("regrant", 32'(bus.dma_gnt), 32'h2);

    // Reset in the middle of a grant, request still held
    bus.dma_stb = 1'b1;
    sys_init = 1'b1; tick();
    check("midrst_gnt", 32'(bus.dma_gnt), 0);
    check("midrst_hold", 32'(bus.cpu_hold), 0);
    check("midrst_bm", 32'(bus.bus_master), 0);
    check("midrst_src", 32'(bus.tmo_src), 0);
    sys_init = 1'b0; tick();
    check("postrst_hold", 32'(bus.cpu_hold), 1);
    check("postrst_gnt_early", 32'(bus.dma_gnt), 0);
    tick();
    check("postrst_gnt", 32'(bus.dma_gnt), 32'h2);

    // Drop and timeout on the same edge
    bus.dma_req = '0; bus.dma_stb = 1'b0;
    repeat (6) tick();
    bus.dma_req = 4'b0001;
    wait_grant(40, waited);
    repeat (TMO - 1) tick();
    check("pre_tmo_gnt", 32'(bus.dma_gnt), 32'h1);
    bus.dma_req = '0;
    tick();
    check("sim_gnt", 32'(bus.dma_gnt), 0);
    check("sim_err", 32'(bus.tmo_err), 0);
    check("sim_src", 32'(bus.tmo_src), 0);
    bus.dma_req = 4'b0001;
    wait_grant(40, waited);
    check("sim_regrant_gap", 32'(waited), 32'(CPU_GAP + 3));
    check("sim_regrant", 32'(bus.dma_gnt), 32'h1);
    bus.dma_req = '0;
    repeat (6) tick();

    // Randomized traffic against the model
    stb_mode = 1'b1;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        r = bus.dma_req;
        r[$urandom_range(0, NREQ - 1)] ^= 1'b1;
        bus.dma_req = r;
      end
      if ($urandom_range(0, 19) == 0) stb_mode = ~stb_mode;
      bus.dma_stb  = stb_mode ? ($urandom_range(0, 3) != 0) : 1'b0;
      bus.cpu_busy = ($urandom_range(0, 2) == 0);
      sys_init     = ($urandom_range(0, 299) == 0);
      tick();
    end
    sys_init = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
